mcp23s17_responder: RTL and testbench
=====================================

# mcp23s17_responder

Cycle-accurate SPI responder that emulates the MCP23S17 GPIO expander register file and interrupt logic, as seen from the MCP23S17 joystick input block. It sits opposite that block's SPI master: in simulation benches and in loop-back builds it lets the joystick reader run with no expander fitted. It decodes MCP23S17 opcode/address/data frames and implements the register subset the reader uses. It drives INTA/INTB from interrupt-on-change on two 8-bit input ports.

## Interface
- HW_ADDR, 3'b000: device hardware address, compared only when IOCON.HAEN=1.
- SYNC_STAGES, 2: flip-flop depth of the cs_n/sck/mosi/gpio input synchronizers (1..3).
- clk  in  1  system clock (28 MHz).
- rst  in  1  reset rst, synchronous, active-high.
- cs_n  in  1  SPI chip select, active-low.
- sck  in  1  SPI clock, mode 0.
- mosi  in  1  SPI data from master.
- miso  out  1  SPI data to master; 0 when not driving.
- miso_oe  out  1  miso output enable; high only during the data bytes of a valid read frame.
- gpioa_in  in  8  port A pin levels (asynchronous).
- gpiob_in  in  8  port B pin levels (asynchronous).
- inta  out  1  port A interrupt, polarity per IOCON.INTPOL.
- intb  out  1  port B interrupt, polarity per IOCON.INTPOL.

## Operation
- Registers (BANK=0 map) and reset values:
  - IODIRA 0x00 = FF and IODIRB 0x01 = FF.
  - GPINTENA 0x04 and GPINTENB 0x05 = 00.
  - IOCON 0x0A/0x0B = 00. One register, two addresses.
  - INTFA 0x0E and INTFB 0x0F = 00. Read-only.
  - INTCAPA 0x10 and INTCAPB 0x11 = 00. Read-only.
  - GPIOA 0x12 and GPIOB 0x13 read the synchronized pin value.
  - Every other address in 0x00..0x15 reads 00, and writes to it are ignored.
- IOCON bits {BANK,MIRROR,SEQOP,DISSLW,HAEN,ODR,INTPOL,-}:
  - BANK and bit0 always read 0.
  - DISSLW and ODR are stored only and have no effect.
- Input sync: cs_n, sck and mosi each pass through SYNC_STAGES flops. sck edges are detected on the synchronized copy.
- Frame state machine: IDLE → OPCODE → ADDR → DATA_WR | DATA_RD, plus IGNORE.
  - IDLE: leave when synchronized cs_n falls. Clear the bit counter and go to OPCODE.
  - OPCODE: shift 8 bits, MSB first, on sck rising edges. The frame is valid when byte[7:4]=0100 and, if HAEN=1, byte[3:1]=HW_ADDR. Valid frames go to ADDR and latch R/W = bit0. Invalid frames go to IGNORE.
  - ADDR: after 8 bits, load the 5-bit pointer = byte[4:0]. A write goes to DATA_WR. A read loads the pointed register into the shift register and goes to DATA_RD.
  - DATA_WR: on each 8th bit, write the pointed register, then advance the pointer.
  - DATA_RD: miso_oe=1. miso presents bit7 of the loaded byte. Each detected sck rising edge shifts out the next bit. On each 8th edge, advance the pointer and load the next register.
  - Pointer advance: +1 with wrap 0x15→0x00 when SEQOP=0; unchanged when SEQOP=1.
  - IGNORE: no register effects and miso_oe=0.
- Any synchronized cs_n rise, in any state: return to IDLE, set miso_oe=0 and miso=0, and discard any partial byte with no write.
- Interrupt-on-change (per port, per bit):
  - Keep a previous-sample register that updates every cycle, including during rst.
  - Change bits = (sync ^ prev) & GPINTEN & IODIR.
  - If the change bits are nonzero and INTFx==0: INTFx <= change bits and INTCAPx <= sync value.
  - If INTFx!=0, further changes are ignored.
- Clear: loading INTCAPx or GPIOx into the read shift register clears INTFx in the same cycle. If a set and a clear happen in the same cycle, the set wins.
- Interrupt outputs:
  - With MIRROR=0: activeA = |INTFA and activeB = |INTFB.
  - With MIRROR=1: both are |INTFA | |INTFB.
  - inta and intb output the active level per INTPOL: 1 = active-high, 0 = active-low.

## Timing
- Reset values: miso=0, miso_oe=0, inta=intb=1 (INTPOL=0, so 1 is the inactive level), all registers at their reset values, state IDLE.
- Register write takes effect 1 clk after the 8th sck rising edge is detected.
- miso updates 1 clk after a rising edge is detected, i.e. SYNC_STAGES+1 clk after the pin edge.
- SCK constraint: each sck phase must last ≥ 2 clk, and the half-period must exceed (SYNC_STAGES+1)/2 clk. SYNC_STAGES=2 meets this with 2 clk per half-bit.
- Pin change to inta/intb: SYNC_STAGES+2 clk.
- Read clear: inta/intb deassert 1 clk after the INTCAP/GPIO load.

## Test plan
- Config: write frames 40 0A 42 and 40 04 FF, then read 41 0A → 42, read 41 0B → 42, read 41 04 → FF.
- Sequential read: gpioa_in=A5, gpiob_in=3C; frame 41 10 00 00 after the previous test → INTCAP 00,00. Frame 41 12 xx xx → A5,3C. With IOCON=62 (SEQOP=1), 41 12 xx xx → A5,A5.
- Interrupt:
  - Set IOCON=42, GPINTENA=FF, gpioa_in FF→FE. inta=1 within 4 clk, INTFA=01, INTCAPA=FE.
  - Then gpioa_in→FC: INTCAPA stays FE.
  - Read 41 10 → FE. inta=0 one clk after the load, and no re-assert without a new change.
- Mirror: IOCON=02 (MIRROR=0), GPINTENB=01, gpiob bit0 toggles → intb=1 and inta=0. Set IOCON=42 → inta=1.
- Abort and bad opcode:
  - cs_n rises after 4 data bits of 40 05 FF → GPINTENB unchanged.
  - Frame 20 05 FF → miso_oe stays 0 and no write occurs.
- Reset mid-frame: assert rst during the 2nd data byte of a read → all registers at reset values, miso_oe=0, inta=1, and no interrupt after release with stable pins.

Source files
------------

// File: rtl/mcp23s17_responder.sv
// SPI responder emulating the MCP23S17 register subset and interrupt-on-change
// logic used by the joystick reader, so the reader can run with no expander fitted.
module mcp23s17_responder #(
    parameter logic [2:0] HW_ADDR     = 3'b000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] gpioa_in,
    input  logic [7:0] gpiob_in,
    output logic       inta,
    output logic       intb
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_OPCODE = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WR     = 3'd3;
    localparam logic [2:0] S_RD     = 3'd4;
    localparam logic [2:0] S_IGNORE = 3'd5;

    logic [SYNC_STAGES-1:0]      cs_sync, sck_sync, mosi_sync;
    logic [SYNC_STAGES-1:0][7:0] ga_sync, gb_sync;
    logic       cs_s, sck_s, mosi_s, cs_d, sck_d;
    logic [7:0] ga_s, gb_s, prev_a, prev_b;

    logic [2:0] state, bitcnt;
    logic [7:0] rx, tx;
    logic [4:0] ptr;
    logic       rw;
    logic [7:0] iodira, iodirb, gpintena, gpintenb, iocon;
    logic [7:0] intfa, intfb, intcapa, intcapb;

    logic       cs_rise, cs_fall, sck_ev, byte_done, op_ok, load_en, wr_en;
    logic       clr_a, clr_b, act_a, act_b;
    logic [7:0] rx_byte, rd_data, chg_a, chg_b;
    logic [4:0] ptr_next, load_addr;

    // Synchronizers and previous samples are never reset: a reset must not
    // fabricate cs/sck edges or pin changes.
    always_ff @(posedge clk) begin
        cs_sync[0]   <= cs_n;
        sck_sync[0]  <= sck;
        mosi_sync[0] <= mosi;
        ga_sync[0]   <= gpioa_in;
        gb_sync[0]   <= gpiob_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            cs_sync[i]   <= cs_sync[i-1];
            sck_sync[i]  <= sck_sync[i-1];
            mosi_sync[i] <= mosi_sync[i-1];
            ga_sync[i]   <= ga_sync[i-1];
            gb_sync[i]   <= gb_sync[i-1];
        end
        cs_d   <= cs_s;
        sck_d  <= sck_s;
        prev_a <= ga_s;
        prev_b <= gb_s;
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ga_s   = ga_sync[SYNC_STAGES-1];
    assign gb_s   = gb_sync[SYNC_STAGES-1];

    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign sck_ev    = sck_s & ~sck_d & ~cs_rise;
    assign rx_byte   = {rx[6:0], mosi_s};
    assign byte_done = sck_ev && (bitcnt == 3'd7);
    assign op_ok     = (rx_byte[7:4] == 4'b0100) && (!iocon[3] || rx_byte[3:1] == HW_ADDR);
    assign ptr_next  = iocon[5] ? ptr : (ptr >= 5'h15) ? 5'h00 : ptr + 5'd1;
    assign load_addr = (state == S_ADDR) ? rx_byte[4:0] : ptr_next;
    assign load_en   = byte_done && ((state == S_ADDR && rw) || state == S_RD);
    assign wr_en     = byte_done && (state == S_WR);
    assign clr_a     = load_en && (load_addr == 5'h10 || load_addr == 5'h12);
    assign clr_b     = load_en && (load_addr == 5'h11 || load_addr == 5'h13);

    assign chg_a = (ga_s ^ prev_a) & gpintena & iodira;
    assign chg_b = (gb_s ^ prev_b) & gpintenb & iodirb;
    assign act_a = iocon[6] ? (|intfa | |intfb) : |intfa;
    assign act_b = iocon[6] ? (|intfa | |intfb) : |intfb;

    assign miso_oe = (state == S_RD);
    assign miso    = miso_oe & tx[7];

    always_comb begin
        case (load_addr)
            5'h00:        rd_data = iodira;
            5'h01:        rd_data = iodirb;
            5'h04:        rd_data = gpintena;
            5'h05:        rd_data = gpintenb;
            5'h0A, 5'h0B: rd_data = iocon;
            5'h0E:        rd_data = intfa;
            5'h0F:        rd_data = intfb;
            5'h10:        rd_data = intcapa;
            5'h11:        rd_data = intcapb;
            5'h12:        rd_data = ga_s;
            5'h13:        rd_data = gb_s;
            default:      rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            bitcnt <= 3'd0;
            rx     <= 8'h00;
            tx     <= 8'h00;
            ptr    <= 5'h00;
            rw     <= 1'b0;
        end else if (cs_rise) begin
            state <= S_IDLE;
            tx    <= 8'h00;
        end else if (state == S_IDLE) begin
            if (cs_fall) begin
                bitcnt <= 3'd0;
                state  <= S_OPCODE;
            end
        end else if (sck_ev) begin
            rx     <= rx_byte;
            bitcnt <= bitcnt + 3'd1;
            tx     <= load_en ? rd_data : {tx[6:0], 1'b0};
            if (bitcnt == 3'd7) begin
                case (state)
                    S_OPCODE: begin
                        if (op_ok) begin
                            rw    <= rx_byte[0];
                            state <= S_ADDR;
                        end else begin
                            state <= S_IGNORE;
                        end
                    end
                    S_ADDR: begin
                        ptr   <= rx_byte[4:0];
                        state <= rw ? S_RD : S_WR;
                    end
                    S_WR, S_RD: ptr <= ptr_next;
                    default: ;
                endcase
            end
        end
    end

    // A new capture takes priority over a read-triggered clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            iodira   <= 8'hFF;
            iodirb   <= 8'hFF;
            gpintena <= 8'h00;
            gpintenb <= 8'h00;
            iocon    <= 8'h00;
            intfa    <= 8'h00;
            intfb    <= 8'h00;
            intcapa  <= 8'h00;
            intcapb  <= 8'h00;
            inta     <= 1'b1;
            intb     <= 1'b1;
        end else begin
            if (wr_en) begin
                case (ptr)
                    5'h00:        iodira   <= rx_byte;
                    5'h01:        iodirb   <= rx_byte;
                    5'h04:        gpintena <= rx_byte;
                    5'h05:        gpintenb <= rx_byte;
                    5'h0A, 5'h0B: iocon    <= rx_byte & 8'h7E;
                    default: ;
                endcase
            end
            if (chg_a != 8'h00 && intfa == 8'h00) begin
                intfa   <= chg_a;
                intcapa <= ga_s;
            end else if (clr_a) begin
                intfa <= 8'h00;
            end
            if (chg_b != 8'h00 && intfb == 8'h00) begin
                intfb   <= chg_b;
                intcapb <= gb_s;
            end else if (clr_b) begin
                intfb <= 8'h00;
            end
            inta <= iocon[1] ? act_a : ~act_a;
            intb <= iocon[1] ? act_b : ~act_b;
        end
    end
endmodule

// File: tb/tb_mcp23s17_responder.sv
// Directed bench for mcp23s17_responder: an SPI master drives frames while a
// register-level model of the expander predicts read data and interrupt levels.
module tb_mcp23s17_responder;
    localparam int HALF   = 4;
    localparam int SETTLE = 6;

    logic       clk = 1'b0;
    logic       rst, cs_n, sck, mosi, miso, miso_oe, inta, intb;
    logic [7:0] gpioa_in, gpiob_in;

    mcp23s17_responder #(.HW_ADDR(3'b000), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .gpioa_in(gpioa_in), .gpiob_in(gpiob_in),
        .inta(inta), .intb(intb)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0, last_evt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register-level model of the expander
    logic [7:0] m_iodir[2], m_gpinten[2], m_intf[2], m_intcap[2], m_iocon;
    logic [7:0] txb[8], rxb[8];

    task automatic m_reset();
        for (int p = 0; p < 2; p++) begin
            m_iodir[p] = 8'hFF; m_gpinten[p] = 8'h00;
            m_intf[p] = 8'h00;  m_intcap[p] = 8'h00;
        end
        m_iocon = 8'h00;
    endtask

    function automatic logic [7:0] m_read(input logic [4:0] a);
        case (a)
            5'h00, 5'h01: return m_iodir[a[0]];
            5'h04, 5'h05: return m_gpinten[a[0]];
            5'h0A, 5'h0B: return m_iocon;
            5'h0E, 5'h0F: return m_intf[a[0]];
            5'h10, 5'h11: return m_intcap[a[0]];
            5'h12:        return gpioa_in;
            5'h13:        return gpiob_in;
            default:      return 8'h00;
        endcase
    endfunction

    task automatic m_write(input logic [4:0] a, input logic [7:0] d);
        case (a)
            5'h00, 5'h01: m_iodir[a[0]] = d;
            5'h04, 5'h05: m_gpinten[a[0]] = d;
            5'h0A, 5'h0B: m_iocon = d & 8'h7E;
            default: ;
        endcase
    endtask

    task automatic m_load(input logic [4:0] a);
        if (a == 5'h10 || a == 5'h12) m_intf[0] = 8'h00;
        if (a == 5'h11 || a == 5'h13) m_intf[1] = 8'h00;
    endtask

    function automatic logic [4:0] m_adv(input logic [4:0] p);
        if (m_iocon[5]) return p;
        return (p >= 5'h15) ? 5'h00 : p + 5'd1;
    endfunction

    function automatic logic m_int(input int p);
        logic act;
        act = m_iocon[6] ? (m_intf[0] != 0 || m_intf[1] != 0) : (m_intf[p] != 0);
        return m_iocon[1] ? act : !act;
    endfunction

    task automatic m_pins(input logic [7:0] na, input logic [7:0] nb);
        logic [7:0] chg, nv[2], ov[2];
        @(negedge clk);
        ov[0] = gpioa_in; ov[1] = gpiob_in; nv[0] = na; nv[1] = nb;
        for (int p = 0; p < 2; p++) begin
            chg = (ov[p] ^ nv[p]) & m_gpinten[p] & m_iodir[p];
            if (chg != 0 && m_intf[p] == 0) begin
                m_intf[p] = chg;
                m_intcap[p] = nv[p];
            end
        end
        gpioa_in = na; gpiob_in = nb;
        last_evt = cyc;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %02h, expected %02h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0b, expected %0b", name, got, exp);
        end
    endtask

    // Interrupt levels always; idle SPI outputs whenever chip select is high.
    always @(negedge clk) begin
        if (cyc - last_evt >= SETTLE) begin
            check1("inta_level", inta, m_int(0));
            check1("intb_level", intb, m_int(1));
            if (cs_n) begin
                check1("idle_miso_oe", miso_oe, 1'b0);
                check1("idle_miso", miso, 1'b0);
            end
        end
    end

    task automatic spi_bit(input logic b, output logic r);
        @(negedge clk);
        mosi = b;
        repeat (HALF) @(negedge clk);
        r = miso;
        sck = 1'b1;
        last_evt = cyc;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] d, output logic [7:0] r);
        logic rb;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(d[i], rb);
            r[i] = rb;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs_n = 1'b1;
        last_evt = cyc;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Full frame of n bytes from txb; read data checked against the model.
    task automatic frame(input int n);
        logic [7:0] r, ex[10];
        logic [4:0] p, np;
        logic valid, rd;
        valid = (txb[0][7:4] == 4'h4) && (!m_iocon[3] || txb[0][3:1] == 3'b000);
        rd = valid && txb[0][0];
        p = 5'h00;
        cs_low();
        for (int k = 0; k < n; k++) begin
            check1("frame_miso_oe", miso_oe, (k >= 2) && rd);
            spi_byte(txb[k], r);
            rxb[k] = r;
            if (valid && k == 1) begin
                p = txb[1][4:0];
                if (rd) begin
                    ex[2] = m_read(p);
                    m_load(p);
                end
            end else if (valid && k >= 2) begin
                np = m_adv(p);
                if (rd) begin
                    check("read_data", rxb[k], ex[k]);
                    ex[k+1] = m_read(np);
                    m_load(np);
                end else begin
                    m_write(p, txb[k]);
                end
                p = np;
            end
        end
        cs_high();
    endtask

    task automatic f3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        txb[0] = a; txb[1] = b; txb[2] = c;
        frame(3);
    endtask

    task automatic rd2(input logic [7:0] a);
        txb[0] = 8'h41; txb[1] = a; txb[2] = 8'h00; txb[3] = 8'h00;
        frame(4);
    endtask

    initial begin
        logic [7:0] r;
        logic rb;
        rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        gpioa_in = 8'hA5; gpiob_in = 8'h3C;
        m_reset();
        repeat (5) @(negedge clk);
        check1("reset_miso", miso, 1'b0);
        check1("reset_miso_oe", miso_oe, 1'b0);
        check1("reset_inta", inta, 1'b1);
        check1("reset_intb", intb, 1'b1);
        rst = 1'b0;
        last_evt = cyc;
        repeat (4) @(negedge clk);

        // configuration write/readback
        f3(8'h40, 8'h0A, 8'h42);
        f3(8'h40, 8'h04, 8'hFF);
        f3(8'h41, 8'h0A, 8'h00); check("iocon_0a", rxb[2], 8'h42);
        f3(8'h41, 8'h0B, 8'h00); check("iocon_0b", rxb[2], 8'h42);
        f3(8'h41, 8'h04, 8'h00); check("gpintena", rxb[2], 8'hFF);

        // sequential reads, then SEQOP holding the pointer
        rd2(8'h10); check("intcapa_rst", rxb[2], 8'h00); check("intcapb_rst", rxb[3], 8'h00);
        rd2(8'h12); check("seq_gpioa", rxb[2], 8'hA5); check("seq_gpiob", rxb[3], 8'h3C);
        f3(8'h40, 8'h0A, 8'h62);
        rd2(8'h12); check("seqop_a0", rxb[2], 8'hA5); check("seqop_a1", rxb[3], 8'hA5);

        // interrupt-on-change
        f3(8'h40, 8'h0A, 8'h42);
        m_pins(8'hFF, 8'h3C);
        repeat (8) @(negedge clk);
        f3(8'h41, 8'h10, 8'h00); check("intcapa_ff", rxb[2], 8'hFF);
        m_pins(8'hFE, 8'h3C);
        repeat (3) @(posedge clk);
        #1 check1("int_lat3", inta, 1'b0);
        @(posedge clk);
        #1 check1("int_lat4", inta, 1'b1);
        repeat (4) @(negedge clk);
        f3(8'h41, 8'h0E, 8'h00); check("intfa", rxb[2], 8'h01);
        m_pins(8'hFC, 8'h3C);
        repeat (8) @(negedge clk);
        f3(8'h41, 8'h10, 8'h00); check("intcapa_hold", rxb[2], 8'hFE);
        check1("int_cleared", inta, 1'b0);
        repeat (20) @(negedge clk);
        check1("no_reassert", inta, 1'b0);

        // mirror
        f3(8'h40, 8'h0A, 8'h02);
        f3(8'h40, 8'h05, 8'h01);
        m_pins(8'hFC, 8'h3D);
        repeat (8) @(negedge clk);
        check1("mirror0_intb", intb, 1'b1);
        check1("mirror0_inta", inta, 1'b0);
        f3(8'h40, 8'h0A, 8'h42);
        repeat (8) @(negedge clk);
        check1("mirror1_inta", inta, 1'b1);
        f3(8'h41, 8'h11, 8'h00); check("intcapb", rxb[2], 8'h3D);

        // abort after 4 data bits, then a bad opcode
        cs_low();
        spi_byte(8'h40, r);
        spi_byte(8'h05, r);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, rb);
        cs_high();
        f3(8'h41, 8'h05, 8'h00); check("abort_nowrite", rxb[2], 8'h01);
        f3(8'h20, 8'h05, 8'hFF);
        f3(8'h41, 8'h05, 8'h00); check("badop_nowrite", rxb[2], 8'h01);

        // hardware addressing: opcode 42 targets address 1, ignored when HAEN=1
        f3(8'h40, 8'h0A, 8'h08);
        f3(8'h42, 8'h04, 8'hAA);
        f3(8'h41, 8'h04, 8'h00); check("haen_filter", rxb[2], 8'hFF);

        // reset during the second data byte of a read
        cs_low();
        spi_byte(8'h41, r);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, rb);
        check1("pre_rst_oe", miso_oe, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        last_evt = cyc;
        repeat (3) @(negedge clk);
        check1("rst_miso_oe", miso_oe, 1'b0);
        check1("rst_inta", inta, 1'b1);
        rst = 1'b0;
        last_evt = cyc;
        repeat (4) @(negedge clk);
        cs_high();
        rd2(8'h00); check("rst_iodira", rxb[2], 8'hFF); check("rst_iodirb", rxb[3], 8'hFF);
        rd2(8'h04); check("rst_gpintena", rxb[2], 8'h00); check("rst_gpintenb", rxb[3], 8'h00);
        f3(8'h41, 8'h0A, 8'h00); check("rst_iocon", rxb[2], 8'h00);
        rd2(8'h0E); check("rst_intfa", rxb[2], 8'h00); check("rst_intfb", rxb[3], 8'h00);
        repeat (20) @(negedge clk);
        check1("post_rst_inta", inta, 1'b1);
        check1("post_rst_intb", intb, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
